mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin tie breaking is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int MEM_ADDR_W_DEF = 10;
  localparam int MEM_DATA_W_DEF = 32;

  // Grant index encoding: port I (instruction miss) and port D (data miss)
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // The port that is not p; used to rotate the tie winner
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational 2-way requester pick.
// MEM_ARB_RR_EN defined : ties go to the port not granted last.
// MEM_ARB_RR_EN undefined: ties always go to port D.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_idx
);

  // Choose a winner among the active requesters
  always_comb begin
    grant_valid = i_req | d_req;
    grant_idx   = PORT_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      grant_idx = other_port(last_grant);
`else
      grant_idx = PORT_D;
`endif
    end else if (d_req) begin
      grant_idx = PORT_D;
    end else begin
      grant_idx = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data_ram port between the I-cache and D-cache
// miss ports. One transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
// Optional round-robin tie breaking via MEM_ARB_RR_EN (default: D wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_DEF,
  parameter int DATA_W = MEM_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // Port I (instruction-cache miss)
  input  logic              i_cs,
  input  logic              i_wea,
  input  logic [ADDR_W-1:0] i_addra,
  input  logic [DATA_W-1:0] i_dina,
  output logic [DATA_W-1:0] i_douta,
  output logic              i_ack,
  // Port D (data-cache miss)
  input  logic              d_cs,
  input  logic              d_wea,
  input  logic [ADDR_W-1:0] d_addra,
  input  logic [DATA_W-1:0] d_dina,
  output logic [DATA_W-1:0] d_douta,
  output logic              d_ack,
  // Shared data_ram
  output logic              mem_cs,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  input  logic              mem_ack,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  logic              pick_valid_s;
  logic              pick_idx_s;

  arb_pick u_pick (
    .i_req       (i_cs),
    .d_req       (d_cs),
`ifdef MEM_ARB_RR_EN
    .last_grant  (last_q),
`endif
    .grant_valid (pick_valid_s),
    .grant_idx   (pick_idx_s)
  );

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= PORT_I;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= PORT_I;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next state: request fields are latched only when leaving IDLE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wea_d   = wea_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = BUSY;
          grant_d = pick_idx_s;
`ifdef MEM_ARB_RR_EN
          last_d  = pick_idx_s;
`endif
          if (pick_idx_s == PORT_D) begin
            wea_d   = d_wea;
            addr_d  = d_addra;
            wdata_d = d_dina;
          end else begin
            wea_d   = i_wea;
            addr_d  = i_addra;
            wdata_d = i_dina;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdata_d = mem_douta;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state and datapath
  assign mem_cs    = (state_q == BUSY);
  assign mem_wea   = wea_q & (state_q == BUSY);
  assign mem_addra = addr_q;
  assign mem_dina  = wdata_q;
  assign i_ack     = (state_q == DONE) && (grant_q == PORT_I);
  assign d_ack     = (state_q == DONE) && (grant_q == PORT_D);
  assign i_douta   = rdata_q;
  assign d_douta   = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// tie and reset sequences, and a randomized run against a reference model.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        i_cs, i_wea, d_cs, d_wea, mem_ack;
  logic [9:0]  i_addra, d_addra;
  logic [31:0] i_dina, d_dina, mem_douta;
  logic [31:0] i_douta, d_douta, mem_dina;
  logic [9:0]  mem_addra;
  logic        i_ack, d_ack, mem_cs, mem_wea, busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cs(i_cs), .i_wea(i_wea), .i_addra(i_addra), .i_dina(i_dina),
    .i_douta(i_douta), .i_ack(i_ack),
    .d_cs(d_cs), .d_wea(d_wea), .d_addra(d_addra), .d_dina(d_dina),
    .d_douta(d_douta), .d_ack(d_ack),
    .mem_cs(mem_cs), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta), .mem_ack(mem_ack),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_cs = 1'b0; d_cs = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        use_d;
    logic        wea;
    logic [9:0]  addr;
    logic [31:0] din;
    int          lat;
    logic [31:0] mdata;
    int          exp_ack_cyc;
    logic [9:0]  exp_addr;
    logic        exp_wea;
    logic [31:0] exp_din;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  // reference-model state for the random run
  int          m_phase;
  logic        m_win, m_wea;
  logic [9:0]  m_addr;
  logic [31:0] m_din, m_rd;
`ifdef MEM_ARB_RR_EN
  logic        m_last;
`endif
  logic [31:0] ram_m [16];
  logic        ri_act, rd_act, ri_wea, rd_wea;
  logic [9:0]  ri_addr, rd_addr;
  logic [31:0] ri_din, rd_din;
  int          gi, gd, wait_c, wi, wd, max_wi, max_wd, ni, nd;
  logic        exp6_i, exp9_i;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 10'h010, 32'h00000000, 0,  32'hDEADBEEF, 3,  10'h010, 1'b0, 32'h00000000, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 10'h3FF, 32'h12345678, 0,  32'hA5A5A5A5, 3,  10'h3FF, 1'b1, 32'h12345678, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 1'b0, 10'h000, 32'h55AA55AA, 10, 32'h0BADF00D, 13, 10'h000, 1'b0, 32'h55AA55AA, 32'h0BADF00D};
    vecs[3] = '{1'b0, 1'b0, 10'h155, 32'h11111111, 1,  32'hFFFFFFFF, 4,  10'h155, 1'b0, 32'h11111111, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 1'b1, 10'h2AA, 32'h00000000, 3,  32'h00000000, 6,  10'h2AA, 1'b1, 32'h00000000, 32'h00000000};
    vecs[5] = '{1'b0, 1'b0, 10'h001, 32'hCAFEF00D, 0,  32'h00000001, 3,  10'h001, 1'b0, 32'hCAFEF00D, 32'h00000001};

    i_wea = 1'b0; d_wea = 1'b0; i_addra = 10'h000; d_addra = 10'h000;
    i_dina = 32'h0; d_dina = 32'h0; mem_douta = 32'h0;
    rst_n = 1'b0; i_cs = 1'b0; d_cs = 1'b0; mem_ack = 1'b0;

    // ---- reset state ----
    #2;
    chk1("rst_mem_cs", mem_cs, 1'b0);
    chk1("rst_mem_wea", mem_wea, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chka("rst_mem_addra", mem_addra, 10'h000);
    chkd("rst_mem_dina", mem_dina, 32'h0);
    chkd("rst_i_douta", i_douta, 32'h0);
    chkd("rst_d_douta", d_douta, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- tie from reset, memory acks immediately ----
`ifdef MEM_ARB_RR_EN
    exp6_i = 1'b1;
`else
    exp6_i = 1'b0;
`endif
    exp9_i = ~exp6_i;
    i_cs = 1'b1; i_addra = 10'h011; i_dina = 32'h1;
    d_cs = 1'b1; d_addra = 10'h022; d_dina = 32'h2;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_cs) begin
        mem_ack = 1'b1;
        mem_douta = 32'h00000100 + {22'd0, mem_addra};
      end else mem_ack = 1'b0;
      if (c == 2) chka("tie1_addr", mem_addra, 10'h022);
      if (c == 3) begin
        chk1("tie1_d_ack", d_ack, 1'b1);
        chk1("tie1_i_ack", i_ack, 1'b0);
        chkd("tie1_d_douta", d_douta, 32'h00000122);
      end
      if (c == 5) chka("tie2_addr", mem_addra, exp6_i ? 10'h011 : 10'h022);
      if (c == 6) begin
        chk1("tie2_i_ack", i_ack, exp6_i);
        chk1("tie2_d_ack", d_ack, ~exp6_i);
      end
      if (c == 9) begin
        chk1("tie3_i_ack", i_ack, exp9_i);
        chk1("tie3_d_ack", d_ack, ~exp9_i);
      end
      if (c == 10) chk1("tie_idle_busy", busy, 1'b0);
      if (i_ack) i_cs = 1'b0;
      if (d_ack && c != 3) d_cs = 1'b0;
    end
    i_cs = 1'b0; d_cs = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;

    // ---- vector table: single transactions with varying memory latency ----
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].use_d) begin
        d_cs = 1'b1; d_wea = vecs[v].wea; d_addra = vecs[v].addr; d_dina = vecs[v].din;
        i_cs = 1'b0; i_addra = 10'($urandom); i_dina = $urandom;
      end else begin
        i_cs = 1'b1; i_wea = vecs[v].wea; i_addra = vecs[v].addr; i_dina = vecs[v].din;
        d_cs = 1'b0; d_addra = 10'($urandom); d_dina = $urandom;
      end
      for (int c = 2; c <= vecs[v].exp_ack_cyc + 1; c++) begin
        @(posedge clk); #1;
        if (c < vecs[v].exp_ack_cyc) begin
          chk1($sformatf("v%0d_mem_cs", v), mem_cs, 1'b1);
          chk1($sformatf("v%0d_busy", v), busy, 1'b1);
          chka($sformatf("v%0d_mem_addra", v), mem_addra, vecs[v].exp_addr);
          chk1($sformatf("v%0d_mem_wea", v), mem_wea, vecs[v].exp_wea);
          chkd($sformatf("v%0d_mem_dina", v), mem_dina, vecs[v].exp_din);
          chk1($sformatf("v%0d_early_ack", v), i_ack | d_ack, 1'b0);
          if (c == vecs[v].exp_ack_cyc - 1) begin
            mem_ack = 1'b1; mem_douta = vecs[v].mdata;
          end else begin
            mem_ack = 1'b0; mem_douta = $urandom;
          end
        end else if (c == vecs[v].exp_ack_cyc) begin
          mem_ack = 1'b0;
          chk1($sformatf("v%0d_d_ack", v), d_ack, vecs[v].use_d);
          chk1($sformatf("v%0d_i_ack", v), i_ack, ~vecs[v].use_d);
          chk1($sformatf("v%0d_done_mem_cs", v), mem_cs, 1'b0);
          chkd($sformatf("v%0d_i_douta", v), i_douta, vecs[v].exp_dout);
          chkd($sformatf("v%0d_d_douta", v), d_douta, vecs[v].exp_dout);
          i_cs = 1'b0; d_cs = 1'b0;
        end else begin
          chk1($sformatf("v%0d_ack_pulse", v), i_ack | d_ack, 1'b0);
          chk1($sformatf("v%0d_idle_busy", v), busy, 1'b0);
          chka($sformatf("v%0d_addr_hold", v), mem_addra, vecs[v].exp_addr);
        end
      end
    end

    // ---- reset asserted in BUSY, then the pending request restarts ----
    d_cs = 1'b1; d_wea = 1'b0; d_addra = 10'h02A; d_dina = 32'h77;
    @(posedge clk); #1;
    chk1("rstb_busy_mem_cs", mem_cs, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk1("rstb_mem_cs", mem_cs, 1'b0);
    chk1("rstb_d_ack", d_ack, 1'b0);
    chk1("rstb_i_ack", i_ack, 1'b0);
    chk1("rstb_busy", busy, 1'b0);
    chka("rstb_mem_addra", mem_addra, 10'h000);
    chkd("rstb_d_douta", d_douta, 32'h0);
    @(posedge clk); #1;
    chk1("rstb_hold_d_ack", d_ack, 1'b0);
    #3; rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rstb_restart_cs", mem_cs, 1'b1);
    chka("rstb_restart_addr", mem_addra, 10'h02A);
    mem_ack = 1'b1; mem_douta = 32'hC0FFEE01;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk1("rstb_d_ack_done", d_ack, 1'b1);
    chk1("rstb_i_ack_done", i_ack, 1'b0);
    chkd("rstb_d_douta_done", d_douta, 32'hC0FFEE01);
    d_cs = 1'b0;
    @(posedge clk); #1;
    chk1("rstb_idle", busy, 1'b0);

    // ---- randomized run against the reference model ----
    do_reset();
    m_phase = 0; m_win = 1'b0; m_wea = 1'b0; m_addr = 10'h000; m_din = 32'h0; m_rd = 32'h0;
`ifdef MEM_ARB_RR_EN
    m_last = 1'b0;
`endif
    for (int k = 0; k < 16; k++) ram_m[k] = $urandom;
    ri_act = 1'b0; rd_act = 1'b0; gi = 0; gd = 0; wait_c = 0;
    wi = 0; wd = 0; max_wi = 0; max_wd = 0; ni = 0; nd = 0;
    ri_wea = 1'b0; rd_wea = 1'b0; ri_addr = 10'h000; rd_addr = 10'h000; ri_din = 32'h0; rd_din = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      // transaction timeline given the inputs present at this edge
      if (m_phase == 0) begin
        if (i_cs || d_cs) begin
          if (i_cs && d_cs) begin
`ifdef MEM_ARB_RR_EN
            m_win = ~m_last;
`else
            m_win = 1'b1;
`endif
          end else m_win = d_cs;
`ifdef MEM_ARB_RR_EN
          m_last = m_win;
`endif
          m_wea  = m_win ? d_wea : i_wea;
          m_addr = m_win ? d_addra : i_addra;
          m_din  = m_win ? d_dina : i_dina;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_ack) begin m_rd = mem_douta; m_phase = 2; end
      end else m_phase = 0;

      chk1("rnd_mem_cs", mem_cs, m_phase == 1);
      chk1("rnd_busy", busy, m_phase != 0);
      chk1("rnd_i_ack", i_ack, (m_phase == 2) && !m_win);
      chk1("rnd_d_ack", d_ack, (m_phase == 2) && m_win);
      chk1("rnd_mem_wea", mem_wea, (m_phase == 1) && m_wea);
      chka("rnd_mem_addra", mem_addra, m_addr);
      chkd("rnd_mem_dina", mem_dina, m_din);
      chkd("rnd_i_douta", i_douta, m_rd);
      chkd("rnd_d_douta", d_douta, m_rd);

      // memory: ack after a random wait, write on ack
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_cs) begin
        if (wait_c == 0) begin
          mem_ack = 1'b1;
          if (mem_wea) begin
            mem_douta = $urandom;
            ram_m[mem_addra[3:0]] = mem_dina;
          end else mem_douta = ram_m[mem_addra[3:0]];
          wait_c = $urandom_range(0, 3);
        end else wait_c--;
      end else mem_ack = 1'b0;

      // requester I
      if (i_ack) begin
        chk1("rnd_i_ack_owner", ri_act, 1'b1);
        if (ri_wea) chkd("rnd_i_write_mem", ram_m[ri_addr[3:0]], ri_din);
        else chkd("rnd_i_read_data", i_douta, ram_m[ri_addr[3:0]]);
        ni++; ri_act = 1'b0; i_cs = 1'b0; wi = 0; gi = $urandom_range(0, 4);
      end else if (!ri_act) begin
        i_addra = 10'($urandom); i_dina = $urandom; i_wea = 1'($urandom);
        if (gi > 0) gi--;
        else if ($urandom_range(0, 2) == 0) begin
          ri_act = 1'b1; ri_wea = 1'($urandom); ri_addr = 10'($urandom_range(0, 15)); ri_din = $urandom;
          i_cs = 1'b1; i_wea = ri_wea; i_addra = ri_addr; i_dina = ri_din;
        end
      end else begin
        wi++; if (wi > max_wi) max_wi = wi;
      end

      // requester D
      if (d_ack) begin
        chk1("rnd_d_ack_owner", rd_act, 1'b1);
        if (rd_wea) chkd("rnd_d_write_mem", ram_m[rd_addr[3:0]], rd_din);
        else chkd("rnd_d_read_data", d_douta, ram_m[rd_addr[3:0]]);
        nd++; rd_act = 1'b0; d_cs = 1'b0; wd = 0; gd = $urandom_range(0, 4);
      end else if (!rd_act) begin
        d_addra = 10'($urandom); d_dina = $urandom; d_wea = 1'($urandom);
        if (gd > 0) gd--;
        else if ($urandom_range(0, 2) == 0) begin
          rd_act = 1'b1; rd_wea = 1'($urandom); rd_addr = 10'($urandom_range(0, 15)); rd_din = $urandom;
          d_cs = 1'b1; d_wea = rd_wea; d_addra = rd_addr; d_dina = rd_din;
        end
      end else begin
        wd++; if (wd > max_wd) max_wd = wd;
      end
    end
    chk1("rnd_i_served", ni > 0, 1'b1);
    chk1("rnd_d_served", nd > 0, 1'b1);
    chk1("rnd_i_wait_bound", max_wi <= 100, 1'b1);
    chk1("rnd_d_wait_bound", max_wd <= 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
